// File: rtl/stream_pkg.sv
// Shared constants for the stream multiplexer.
//   sel_w_to_ch : number of channels addressed by a select of the given width.
package stream_pkg;

    function automatic int sel_w_to_ch(input int sel_w);
        return 2 ** sel_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Rotates the request vector so that channel ptr sits at position 0, picks the
// lowest set bit, then rotates the one-hot result back to channel order.
//   req   in  CH  request per channel
//   ptr   in  PW  highest-priority channel this cycle
//   grant out CH  one-hot grant, or zero when nothing is requested
module rr_arbiter #(
    parameter int CH = 4,
    localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic [CH-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [CH-1:0] grant
);

    logic [CH-1:0] rot;
    logic [CH-1:0] rot_gnt;

    always_comb begin
        logic [PW-1:0] idx;
        rot   = '0;
        grant = '0;
        // CH is a power of two, so the PW-bit add wraps modulo CH for free.
        for (int j = 0; j < CH; j++) begin
            idx    = ptr + PW'(j);
            rot[j] = req[idx];
        end
        // Isolate the lowest set bit: first requester at or after ptr.
        rot_gnt = rot & (~rot + CH'(1));
        for (int j = 0; j < CH; j++) begin
            idx        = ptr + PW'(j);
            grant[idx] = rot_gnt[j];
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered CH:1 stream multiplexer with fixed-select or round-robin choice.
//   clk, rst_n            clock, async active-low reset
//   mode                  0 = fixed (sel), 1 = round-robin
//   sel                   channel for fixed mode
//   in_valid/in_data      CH producer streams, channel i at [i*DATA_W +: DATA_W]
//   in_ready              per-channel ready, at most one bit high
//   out_valid/out_data    single output register with back-pressure
//   out_ch                channel that supplied out_data
//   out_ready             downstream accepts
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    localparam int CH    = sel_w_to_ch(SEL_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [CH-1:0]        in_valid,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic [CH-1:0]        in_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEL_W-1:0]     out_ch,
    input  logic                 out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic              load_en;
    logic [CH-1:0]     g_fix, g_rr, g;
    logic              any_g;
    logic [SEL_W-1:0]  k;

    rr_arbiter #(.CH(CH)) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (g_rr)
    );

    // Output stage can take a word when empty or draining this cycle.
    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        g_fix      = '0;
        g_fix[sel] = in_valid[sel];
        g          = mode ? g_rr : g_fix;
        any_g      = |g;
        k          = '0;
        for (int i = 0; i < CH; i++) begin
            if (g[i]) k = SEL_W'(i);
        end
    end

    // out_valid_q is already 0 in reset, so gate on rst_n explicitly to keep
    // producers from seeing a handshake that the register will never take.
    assign in_ready = rst_n ? (g & {CH{load_en}}) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (any_g) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[k*DATA_W +: DATA_W];
                out_ch_d    = k;
                if (mode) ptr_d = k + SEL_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshakes. Successor to the combinational 2**n:1 mux: selects one of CH = 2**SEL_W input streams per cycle, either by an explicit select (fixed mode) or by round-robin arbitration. It registers the chosen word into a single output stage with back-pressure. It sits between multiple producer channels and one shared downstream consumer.

## Interface
- SEL_W, default 2: select width; channel count CH = 2**SEL_W (legal 1..4).
- DATA_W, default 8: data width per channel.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low; release is synchronised externally.
- mode  in  1  0 = fixed (use sel), 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
- in_valid  in  CH  per-channel valid.
- in_data  in  CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  CH  per-channel ready; at most one bit high in any cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  downstream accepts.

## Operation
- Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- load_en = !out_valid | out_ready. The output stage accepts a new word whenever it is empty or being drained in the same cycle.
- Grant vector g (combinational, one-hot or zero):
  - Fixed mode: g[sel] = in_valid[sel]; all other bits 0.
  - Round-robin mode: g selects the first channel with in_valid set, searching ptr, ptr+1, ... CH-1, 0, ... ptr-1 (wrap modulo CH).
- in_ready = g & {CH{load_en}}.
- When some g[k] is set and load_en is high: out_data <= channel k data, out_ch <= k, out_valid <= 1. In round-robin mode only, ptr <= (k+1) mod CH.
- When out_valid & out_ready and no grant: out_valid <= 0. out_data and out_ch hold their last values.
- ptr does not change in fixed mode and does not change on cycles with no input transfer. Switching mode takes effect in the same cycle's grant and leaves ptr intact.
- No combinational path from in_valid/in_data to out_*. There is a combinational path from out_ready to in_ready; this is intentional.

## Timing
- Reset (rst_n low, immediate): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is forced to 0 while rst_n is low.
- Latency: a word accepted at edge t is visible on out_* after edge t and is transferable at edge t+1.
- Throughput: 1 word/cycle while out_ready stays high.
- Back-pressure: when out_valid=1 and out_ready=0, in_ready is all zeros and out_* hold stable.
- Simultaneous drain and load in one cycle: the new word replaces the old one with no bubble.
- Fairness (round-robin mode): with all CH channels continuously valid and out_ready=1, grants cycle 0,1,..,CH-1,0,...
- Fixed mode with sel pointing at an idle channel: no grant, even if other channels are valid.
- Reset mid-transfer: any held word is discarded and ptr returns to 0.

## Structure
- Constants go in a shared package stream_pkg: function sel_w_to_ch(sel_w) = 2**sel_w. No typedefs are required.
- One sub-module, rr_arbiter (params CH; ports req[CH], ptr[clog2 CH], grant[CH]). It is purely combinational rotate / priority-encode / rotate-back. Pointer update and the datapath stay in stream_mux_rr.
- Target size: about 150 lines of RTL total.

## Test plan
- Reset: assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; after release with only ch2 valid in RR mode, ch2 is granted.
- Fixed mode, SEL_W=2, DATA_W=8: ch0=0xA5, ch1=0x3C, ch2=0x7E, ch3=0xF0, all valid, out_ready=1; sel=0,1,2,3 on successive cycles -> out_data = A5, 3C, 7E, F0 with out_ch = 0,1,2,3, each 1 cycle after selection.
- Round-robin fairness: all four channels valid for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and in_ready one-hot in the same order.
- Sparse round-robin: only ch1 and ch3 valid, ptr=0 -> grants 1,3,1,3; then drop ch3 -> grants 1,1.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0000 and out_data stable; raise out_ready -> the next word loads in the same cycle with no bubble.
- Fixed mode, idle select: sel=2 with in_valid=1011 -> in_ready=0000; out_valid falls after the held word drains.
